// File: rtl/rmux_cfg_loader_pkg.sv
// Shared definitions for the routing-mux configuration loader.
package rmux_cfg_loader_pkg;

  localparam logic MODE_I0 = 1'b0;
  localparam logic MODE_I1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLatch = 2'd2
  } state_e;

endpackage

// File: rtl/rmux_cfg_shifter.sv
// Parallel-load left shift register with bit down-counter; exposes the MSB it will hold next.
module rmux_cfg_shifter #(
  parameter int unsigned L     = 2,
  parameter int unsigned CNT_W = (L > 1) ? $clog2(L) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [L-1:0] load_data,
  input  logic         shift,
  output logic         next_msb,
  output logic         last
);

  logic [L-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = CNT_W'(L - 1);
    end else if (shift) begin
      data_d = data_q << 1;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  assign next_msb = data_d[L-1];
  assign last     = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rmux_cfg_loader.sv
// Shadow-register config loader: shifts the committed image onto a serial chain, then latches it.
module rmux_cfg_loader
  import rmux_cfg_loader_pkg::*;
#(
  parameter int unsigned N_MUX = 2,
  parameter int unsigned SEL_W = 1,
  parameter int unsigned IDX_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [SEL_W-1:0]       wr_sel,
  input  logic                   commit_valid,
  output logic                   commit_ready,
  output logic                   cfg_sdo,
  output logic                   cfg_sen,
  output logic                   cfg_latch,
  output logic [N_MUX*SEL_W-1:0] sel_o,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned L = N_MUX * SEL_W;

  state_e         state_q;
  logic [L-1:0]   shadow_q, shadow_next, snap_q;
  logic           wr_fire, commit_fire, in_range;
  logic           next_msb, last;

  assign wr_ready     = rst_n && (state_q == StIdle);
  assign commit_ready = rst_n && (state_q == StIdle);
  assign wr_fire      = wr_valid && wr_ready;
  assign commit_fire  = commit_valid && commit_ready;
  assign in_range     = int'(wr_idx) < int'(N_MUX);

  // Merged view so a same-cycle write lands in the commit snapshot.
  always_comb begin
    shadow_next = shadow_q;
    if (wr_fire && in_range) begin
      for (int k = 0; k < int'(N_MUX); k++) begin
        if (k == int'(wr_idx)) shadow_next[k*SEL_W +: SEL_W] = wr_sel;
      end
    end
  end

  rmux_cfg_shifter #(
    .L (L)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (commit_fire),
    .load_data (shadow_next),
    .shift     (state_q == StShift),
    .next_msb  (next_msb),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shadow_q  <= {N_MUX{SEL_W'(MODE_I0)}};
      snap_q    <= '0;
      sel_o     <= '0;
      cfg_sdo   <= 1'b0;
      cfg_sen   <= 1'b0;
      cfg_latch <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err      <= wr_fire && !in_range;
      shadow_q <= shadow_next;
      unique case (state_q)
        StIdle: begin
          if (commit_fire) begin
            snap_q  <= shadow_next;
            cfg_sen <= 1'b1;
            cfg_sdo <= next_msb;
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (last) begin
            cfg_sen   <= 1'b0;
            cfg_sdo   <= 1'b0;
            cfg_latch <= 1'b1;
            state_q   <= StLatch;
          end else begin
            cfg_sdo <= next_msb;
          end
        end
        StLatch: begin
          sel_o     <= snap_q;
          cfg_latch <= 1'b0;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rmux_cfg_loader.sv
// Directed bench for rmux_cfg_loader with N_MUX=2, SEL_W=1, IDX_W=2.
module tb_rmux_cfg_loader;
  import rmux_cfg_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, commit_valid;
  logic [1:0] wr_idx;
  logic [0:0] wr_sel;
  logic       wr_ready, commit_ready, cfg_sdo, cfg_sen, cfg_latch, busy, err;
  logic [1:0] sel_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rmux_cfg_loader #(
    .N_MUX (2),
    .SEL_W (1),
    .IDX_W (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_idx       (wr_idx),
    .wr_sel       (wr_sel),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .cfg_sdo      (cfg_sdo),
    .cfg_sen      (cfg_sen),
    .cfg_latch    (cfg_latch),
    .sel_o        (sel_o),
    .busy         (busy),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller drives the commit (and optional write) for cycle T; this walks T+1..T+4.
  task automatic run_commit(input string tag, input logic [1:0] bits, input logic [1:0] exp_sel,
                            input bit clr_wr);
    step();
    commit_valid = 1'b0;
    if (clr_wr) wr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check({tag, "_sen"}, cfg_sen, 1);
      check({tag, "_sdo"}, cfg_sdo, bits[1-i]);
      check({tag, "_busy"}, busy, 1);
      step();
    end
    check({tag, "_latch"}, cfg_latch, 1);
    check({tag, "_sen_off"}, cfg_sen, 0);
    step();
    check({tag, "_sel"}, sel_o, exp_sel);
    check({tag, "_latch_off"}, cfg_latch, 0);
    check({tag, "_cready"}, commit_ready, 1);
  endtask

  initial begin
    int sen_seen;
    rst_n = 1'b0; wr_valid = 1'b0; commit_valid = 1'b0; wr_idx = '0; wr_sel = '0;
    step(); step();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_commit_ready", commit_ready, 0);
    check("rst_sel", sel_o, 2'b00);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("idle_wr_ready", wr_ready, 1);
    sen_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cfg_sen) sen_seen++;
    end
    check("idle_no_sen", sen_seen, 0);
    check("idle_busy", busy, 0);
    check("idle_sel", sel_o, 2'b00);

    // Write idx1=I1, then commit: bits 1,0 and sel 10.
    wr_valid = 1'b1; wr_idx = 2'd1; wr_sel = MODE_I1;
    step();
    wr_valid = 1'b0;
    check("wr_no_sel_effect", sel_o, 2'b00);
    commit_valid = 1'b1;
    run_commit("c1", 2'b10, 2'b10, 1'b0);

    // Same-cycle write idx0=I1 merges into snapshot.
    wr_valid = 1'b1; wr_idx = 2'd0; wr_sel = MODE_I1; commit_valid = 1'b1;
    run_commit("c2", 2'b11, 2'b11, 1'b1);

    // Out-of-range write: err pulse, image unchanged.
    wr_valid = 1'b1; wr_idx = 2'd2; wr_sel = 1'b0;
    step();
    wr_valid = 1'b0;
    check("err_pulse", err, 1);
    step();
    check("err_clear", err, 0);
    commit_valid = 1'b1;
    run_commit("c3", 2'b11, 2'b11, 1'b0);

    // Write held during SHIFT stalls until T+4 and is excluded from the in-flight image.
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    wr_valid = 1'b1; wr_idx = 2'd1; wr_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_wr_stall", wr_ready, 0);
      step();
    end
    check("hold_wr_ready", wr_ready, 1);
    check("hold_sel_excl", sel_o, 2'b11);
    step();
    wr_valid = 1'b0;
    commit_valid = 1'b1;
    run_commit("c4", 2'b01, 2'b01, 1'b0);

    // Reset mid-SHIFT aborts: no latch, sel cleared, shadow cleared.
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    step();
    check("abort_sen", cfg_sen, 1);
    rst_n = 1'b0;
    step();
    check("abort_latch", cfg_latch, 0);
    check("abort_sel", sel_o, 2'b00);
    check("abort_sen_off", cfg_sen, 0);
    check("abort_wr_ready", wr_ready, 0);
    step();
    check("abort_latch2", cfg_latch, 0);
    rst_n = 1'b1;
    #1;
    check("abort_wr_ready_back", wr_ready, 1);
    commit_valid = 1'b1;
    run_commit("c5", 2'b00, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
